// File: rtl/hwpe_stream_sink_realign_ctrl.sv
// Sink realigner sequencer: walks strided lines and emits first/last/flush.
// Optional stall counter enabled by HWPE_SINK_REALIGN_CTRL_PERF_EN.
package hwpe_stream_sink_realign_ctrl_pkg;

  localparam int unsigned CTRL_LEN_W = 16;

  typedef struct packed {
    logic                  enable;
    logic                  strb_valid;
    logic                  realign;
    logic                  first;
    logic                  last;
    logic                  last_packet;
    logic [CTRL_LEN_W-1:0] line_length;
  } ctrl_realign_t;

endpackage

module hwpe_stream_sink_realign_ctrl
  import hwpe_stream_sink_realign_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned BW = DATA_WIDTH / 8,
  localparam int unsigned OW = $clog2(BW)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [OW-1:0]        offset_i,
  input  logic [CNT_WIDTH-1:0] line_length_i,
  input  logic [CNT_WIDTH-1:0] num_lines_i,
  input  logic                 push_valid_i,
  input  logic                 push_ready_i,
  input  logic                 pop_ready_i,
  output ctrl_realign_t        ctrl_o,
  output logic [BW-1:0]        strb_o,
`ifdef HWPE_SINK_REALIGN_CTRL_PERF_EN
  output logic [31:0]          stall_cnt_o,
`endif
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE, FIRST, MID, FLUSH, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        off_q, off_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] nl_q, nl_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;

  logic mis;
  logic hs;
  logic eol;
  logic in_data;

  assign mis = (off_q != '0);
  assign hs  = push_valid_i & push_ready_i;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    len_d      = len_q;
    nl_d       = nl_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    eol        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (line_length_i == '0 || num_lines_i == '0) begin
            state_d = DONE;
          end else begin
            off_d      = offset_i;
            len_d      = line_length_i;
            nl_d       = num_lines_i;
            word_cnt_d = '0;
            line_cnt_d = '0;
            state_d    = FIRST;
          end
        end
      end
      FIRST: begin
        if (hs) begin
          if (len_q == CNT_WIDTH'(1)) begin
            if (mis) state_d = FLUSH;
            else     eol     = 1'b1;
          end else begin
            word_cnt_d = CNT_WIDTH'(1);
            state_d    = MID;
          end
        end
      end
      MID: begin
        if (hs) begin
          if (word_cnt_q == len_q - 1'b1) begin
            if (mis) state_d = FLUSH;
            else     eol     = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (pop_ready_i) eol = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // end-of-line: either finish the transfer or rewind to the next line
    if (eol) begin
      if (line_cnt_q == nl_q - 1'b1) begin
        state_d = DONE;
      end else begin
        line_cnt_d = line_cnt_q + 1'b1;
        word_cnt_d = '0;
        state_d    = FIRST;
      end
    end
    if (clear_i) begin
      state_d    = IDLE;
      off_d      = '0;
      len_d      = '0;
      nl_d       = '0;
      word_cnt_d = '0;
      line_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      off_q      <= '0;
      len_q      <= '0;
      nl_q       <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      len_q      <= len_d;
      nl_q       <= nl_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

`ifdef HWPE_SINK_REALIGN_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_ev;

  assign stall_ev =
    ((state_q == FIRST || state_q == MID) & push_valid_i & ~push_ready_i) |
    ((state_q == FLUSH) & ~pop_ready_i);

  always_comb begin
    stall_d = stall_q;
    if (stall_ev && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 1'b1;
    if (state_q == IDLE && start_i) stall_d = '0;
    if (clear_i) stall_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

  assign in_data = (state_q == FIRST) | (state_q == MID) | (state_q == FLUSH);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign strb_o  = in_data ? ({BW{1'b1}} << off_q) : '0;

  always_comb begin
    ctrl_o             = '0;
    ctrl_o.enable      = busy_o;
    ctrl_o.strb_valid  = in_data;
    ctrl_o.realign     = busy_o & mis;
    ctrl_o.first       = (state_q == FIRST);
    ctrl_o.last        = (state_q == FLUSH);
    ctrl_o.last_packet = (state_q == DONE);
    ctrl_o.line_length = CTRL_LEN_W'(len_q);
  end

endmodule

// File: tb/tb_hwpe_stream_sink_realign_ctrl.sv
// Directed bench for the sink realigner sequencer.
// Build with HWPE_SINK_REALIGN_CTRL_PERF_EN to also check the stall counter.
module tb_hwpe_stream_sink_realign_ctrl;
  import hwpe_stream_sink_realign_ctrl_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    offset_i = '0;
  logic [15:0]   line_length_i = '0;
  logic [15:0]   num_lines_i = '0;
  logic          push_valid_i = 1'b0;
  logic          push_ready_i = 1'b0;
  logic          pop_ready_i = 1'b0;
  ctrl_realign_t ctrl_o;
  logic [3:0]    strb_o;
  logic          busy_o;
  logic          done_o;
`ifdef HWPE_SINK_REALIGN_CTRL_PERF_EN
  logic [31:0]   stall_cnt_o;
`endif

  hwpe_stream_sink_realign_ctrl #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .offset_i     (offset_i),
    .line_length_i(line_length_i),
    .num_lines_i  (num_lines_i),
    .push_valid_i (push_valid_i),
    .push_ready_i (push_ready_i),
    .pop_ready_i  (pop_ready_i),
    .ctrl_o       (ctrl_o),
    .strb_o       (strb_o),
`ifdef HWPE_SINK_REALIGN_CTRL_PERF_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  int          beats, firsts, first_cyc, flushes, flush_cyc, stalls, done_cyc;
  logic [31:0] first_mask;
  logic [3:0]  strb_and, strb_or;
  logic        realign_or, lp_at_done;
  logic [15:0] ll_at_done;
  logic [31:0] perf_at_done;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_xfer(input logic [1:0] off, input logic [15:0] len,
                          input logic [15:0] nl, input bit toggle,
                          input int pop_stall, input int glitch_cyc);
    int  fc;
    int  total;
    logic hs, data;
    beats = 0; firsts = 0; first_cyc = 0; flushes = 0; flush_cyc = 0;
    stalls = 0; done_cyc = -1; first_mask = '0; strb_and = 4'hF;
    strb_or = '0; realign_or = 1'b0; lp_at_done = 1'b0;
    ll_at_done = '0; perf_at_done = '0;
    fc = 0; total = 0;
    offset_i = off; line_length_i = len; num_lines_i = nl;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done_o) begin
        done_cyc   = cyc;
        lp_at_done = ctrl_o.last_packet;
        ll_at_done = ctrl_o.line_length;
`ifdef HWPE_SINK_REALIGN_CTRL_PERF_EN
        perf_at_done = stall_cnt_o;
`endif
        break;
      end
      start_i = (cyc == glitch_cyc);
      if (start_i) begin
        offset_i = 2'd3; line_length_i = 16'd1; num_lines_i = 16'd1;
      end
      push_valid_i = 1'b1;
      push_ready_i = toggle ? (cyc % 2 == 1) : 1'b1;
      pop_ready_i  = ctrl_o.last ? (fc >= pop_stall) : 1'b1;
      if (ctrl_o.last) begin
        fc++;
        flush_cyc++;
      end
      hs   = push_valid_i & push_ready_i;
      data = ctrl_o.strb_valid & ~ctrl_o.last;
      if (ctrl_o.strb_valid) begin
        strb_and = strb_and & strb_o;
        strb_or  = strb_or | strb_o;
      end
      realign_or = realign_or | ctrl_o.realign;
      if (ctrl_o.first) first_cyc++;
      if (data & hs) begin
        if (ctrl_o.first) begin
          firsts++;
          first_mask = first_mask | (32'd1 << total);
        end
        beats++;
        total++;
      end
      if (ctrl_o.last & pop_ready_i) begin
        flushes++;
        total++;
      end
      if ((data & ~push_ready_i) | (ctrl_o.last & ~pop_ready_i)) stalls++;
      tick();
    end
    start_i = 1'b0;
    push_valid_i = 1'b0;
    check("timeout", 32'(done_cyc >= 0), 32'd1);
  endtask

  initial begin
    #3;
    check("rst_ctrl", 32'(ctrl_o), 32'd0);
    check("rst_strb", 32'(strb_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // aligned, two lines of four words
    run_xfer(2'd0, 16'd4, 16'd2, 1'b0, 0, -1);
    check("al_beats", 32'(beats), 32'd8);
    check("al_firstmask", first_mask, 32'h11);
    check("al_flush", 32'(flush_cyc), 32'd0);
    check("al_realign", 32'(realign_or), 32'd0);
    check("al_strb_and", 32'(strb_and), 32'hF);
    check("al_strb_or", 32'(strb_or), 32'hF);
    check("al_done_cyc", 32'(done_cyc), 32'd8);
    check("al_lp", 32'(lp_at_done), 32'd1);
    check("al_ll", 32'(ll_at_done), 32'd4);
    tick();
    check("al_idle_busy", 32'(busy_o), 32'd0);
    check("al_idle_done", 32'(done_o), 32'd0);

    // misaligned by one byte, single line of three
    run_xfer(2'd1, 16'd3, 16'd1, 1'b0, 0, -1);
    check("mis_beats", 32'(beats), 32'd3);
    check("mis_flush", 32'(flushes), 32'd1);
    check("mis_firstmask", first_mask, 32'h1);
    check("mis_realign", 32'(realign_or), 32'd1);
    check("mis_strb_and", 32'(strb_and), 32'hE);
    check("mis_strb_or", 32'(strb_or), 32'hE);
    check("mis_done_cyc", 32'(done_cyc), 32'd4);
    tick();

    // backpressure on both sides
    run_xfer(2'd2, 16'd2, 16'd1, 1'b1, 3, -1);
    check("bp_first_cyc", 32'(first_cyc), 32'd2);
    check("bp_beats", 32'(beats), 32'd2);
    check("bp_flush_cyc", 32'(flush_cyc), 32'd4);
    check("bp_strb", 32'(strb_or), 32'hC);
    check("bp_done_cyc", 32'(done_cyc), 32'd8);
`ifdef HWPE_SINK_REALIGN_CTRL_PERF_EN
    check("bp_stall_cnt", perf_at_done, 32'd5);
`endif
    check("bp_stalls_seen", 32'(stalls), 32'd5);
    tick();

    // one-word lines, maximum offset
    run_xfer(2'd3, 16'd1, 16'd3, 1'b0, 0, -1);
    check("dg_total", 32'(beats + flushes), 32'd6);
    check("dg_flush", 32'(flushes), 32'd3);
    check("dg_firstmask", first_mask, 32'h15);
    check("dg_strb_and", 32'(strb_and), 32'h8);
    check("dg_strb_or", 32'(strb_or), 32'h8);
    check("dg_done_cyc", 32'(done_cyc), 32'd6);
    tick();

    // zero length goes straight to done
    run_xfer(2'd0, 16'd0, 16'd5, 1'b0, 0, -1);
    check("z_done_cyc", 32'(done_cyc), 32'd0);
    check("z_first", 32'(first_cyc), 32'd0);
    check("z_strb", 32'(strb_or), 32'd0);
    tick();

    // clear in the middle of a line
    begin
      logic done_seen;
      done_seen = 1'b0;
      offset_i = 2'd1; line_length_i = 16'd8; num_lines_i = 16'd1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      push_valid_i = 1'b1; push_ready_i = 1'b1; pop_ready_i = 1'b1;
      repeat (3) tick();
      check("clr_pre_busy", 32'(busy_o), 32'd1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clr_busy", 32'(busy_o), 32'd0);
      check("clr_ctrl", 32'(ctrl_o), 32'd0);
      check("clr_strb", 32'(strb_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
        done_seen = done_seen | done_o;
        tick();
      end
      push_valid_i = 1'b0;
      check("clr_no_done", 32'(done_seen), 32'd0);
    end
    run_xfer(2'd1, 16'd8, 16'd1, 1'b0, 0, -1);
    check("clr_rerun_total", 32'(beats + flushes), 32'd9);
    check("clr_rerun_done", 32'(done_cyc), 32'd9);
    tick();

    // start while busy must be ignored
    run_xfer(2'd0, 16'd4, 16'd2, 1'b0, 0, 2);
    check("gl_beats", 32'(beats), 32'd8);
    check("gl_strb", 32'(strb_or), 32'hF);
    check("gl_ll", 32'(ll_at_done), 32'd4);
    check("gl_done_cyc", 32'(done_cyc), 32'd8);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_sink_realign_ctrl.md
Name: hwpe_stream_sink_realign_ctrl

Overview:
- Sequencer that drives the control interface and reference strobe of the sink realigner for strided line writes.
- Given a byte offset, a line length and a line count, it walks every line word by word by observing the realigner's input and output handshakes.
- Emits `first`/`last`/`last_packet` and the reference strobe, and inserts one flush beat per misaligned line.
- Sits between the streamer's address generator and the sink realigner.

Parameters:
- DATA_WIDTH, 32: stream width in bits; BW = DATA_WIDTH/8 bytes; OW = $clog2(BW).
- CNT_WIDTH, 16: width of the word and line counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- start_i  in  1  start pulse; sampled in IDLE only
- offset_i  in  OW  byte offset of the line base within a word; sampled at start
- line_length_i  in  CNT_WIDTH  words per line; sampled at start
- num_lines_i  in  CNT_WIDTH  lines per transfer; sampled at start
- push_valid_i  in  1  realigner input valid (observed)
- push_ready_i  in  1  realigner input ready (observed)
- pop_ready_i  in  1  realigner output ready (observed)
- ctrl_o  out  ctrl_realign_t  control to the realigner
- strb_o  out  BW  reference strobe to the realigner
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle end-of-transfer pulse

Behaviour:
- Reset (rst_ni=0, asynchronous) or clear_i=1 (synchronous, priority over everything else):
  - state=IDLE; counters=0; sampled registers=0.
  - All outputs 0, ctrl_o all fields 0. clear_i never produces done_o.
- Registered copies: off_q, len_q, nl_q; word_cnt and line_cnt, both CNT_WIDTH wide.
- mis = (off_q != 0).
- States:
  - IDLE: start_i=1 with line_length_i=0 or num_lines_i=0 -> DONE directly, no data beats. Otherwise sample inputs, zero counters -> FIRST. start_i is ignored outside IDLE.
  - FIRST: ctrl_o.first=1, held until the beat handshake (push_valid_i & push_ready_i).
    - On handshake with len_q==1: mis -> FLUSH; !mis -> end-of-line.
    - On handshake otherwise: word_cnt=1 -> MID.
  - MID: on handshake, word_cnt++.
    - On the handshake where word_cnt == len_q-1: mis -> FLUSH; !mis -> end-of-line.
  - FLUSH: ctrl_o.last=1 (the realigner holds push ready low). Advances on pop_ready_i=1 -> end-of-line.
  - end-of-line:
    - If line_cnt == nl_q-1 -> DONE.
    - Else line_cnt++, word_cnt=0 -> FIRST.
  - DONE: ctrl_o.last_packet=1, done_o=1 for exactly one cycle -> IDLE.
- Outputs are Moore, decoded from registered state only; there is no combinational path from handshake inputs to outputs.
- ctrl_o fields:
  - enable = busy_o.
  - strb_valid = (state in FIRST, MID, FLUSH).
  - realign = mis, valid in all non-IDLE states.
  - line_length = len_q.
- strb_o:
  - In FIRST/MID/FLUSH: ({BW{1'b1}} << off_q), i.e. ones on bytes off_q..BW-1.
  - In IDLE/DONE: 0.
- busy_o = (state != IDLE).
- Beat counts:
  - Misaligned: len_q+1 output beats per line.
  - Aligned: len_q beats per line.
- Handshake arriving in the same cycle as clear_i is discarded.
- Counters never wrap: lengths are bounded by 2^CNT_WIDTH-1 and compared before increment.

Optional Feature:
- Macro: HWPE_SINK_REALIGN_CTRL_PERF_EN
- Defined: adds output stall_cnt_o [31:0].
  - Counts cycles with state in FIRST/MID and push_valid_i & ~push_ready_i, plus cycles in FLUSH with ~pop_ready_i.
  - Reset/clear to 0 and on every accepted start; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Aligned (offset=0, len=4, lines=2, ready always 1) -> 8 beats, first on beats 0 and 4, realign=0, no last, strb_o=4'hF; last_packet and done_o together one cycle after the final handshake.
- Misaligned (offset=1, len=3, lines=1, DATA_WIDTH=32) -> strb_o=4'hE, realign=1, first beat 0, beats 1-2 in MID, then a FLUSH beat with last=1; done_o after pop_ready_i.
- Backpressure (offset=2, len=2, push_ready_i toggling 1/0, pop_ready_i=0 for 3 cycles in FLUSH) -> first held until the handshake; FLUSH lasts 4 cycles; with PERF_EN, stall_cnt_o equals the injected stall count.
- Degenerate (len=1, offset=3, lines=3) -> per line FIRST then FLUSH, 6 beats total, strb_o=4'h8; len=0 -> done_o the cycle after start, no first.
- clear_i mid-MID (offset=1, len=8, after 3 beats) -> next cycle IDLE, all outputs 0, no done_o; a fresh start then runs the full sequence normally.
- start_i pulsed while busy -> ignored; sampled parameters unchanged; beat count unchanged.
